// File: rtl/async_mutex_client.sv
// Client-side FSM handshaking a core with an asynchronous mutex element.
// Define ASYNC_MUTEX_CLIENT_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES.
module async_mutex_client #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic acq,
  input  logic rel,
  output logic req_o,
  input  logic gnt_i,
  output logic held,
  output logic busy,
  output logic ack,
  output logic nack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HELD,
    ST_REL
  } state_t;

  state_t r_state;
  logic   r_req_o;
  logic   r_held;
  logic   r_busy;
  logic   r_ack;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_gnt_s;

  // gnt_i is asynchronous; nothing else may look at it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gnt_i};
    end
  end

  assign w_gnt_s = r_sync[SYNC_STAGES-1];

`ifdef ASYNC_MUTEX_CLIENT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_nack;
  logic          w_timeout;

  // Counts cycles already spent in REQ; zero whenever outside REQ
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_REQ) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign nack      = r_nack;
`else
  assign nack = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req_o <= 1'b0;
      r_held  <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
`ifdef ASYNC_MUTEX_CLIENT_TIMEOUT_EN
      r_nack  <= 1'b0;
`endif
    end else begin
      r_ack  <= 1'b0;
`ifdef ASYNC_MUTEX_CLIENT_TIMEOUT_EN
      r_nack <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (acq) begin
            r_state <= ST_REQ;
            r_req_o <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          // a grant seen on the timeout cycle still wins
          if (w_gnt_s) begin
            r_state <= ST_HELD;
            r_held  <= 1'b1;
            r_ack   <= 1'b1;
          end
`ifdef ASYNC_MUTEX_CLIENT_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= ST_REL;
            r_req_o <= 1'b0;
            r_nack  <= 1'b1;
          end
`endif
        end
        ST_HELD: begin
          if (rel) begin
            r_state <= ST_REL;
            r_req_o <= 1'b0;
            r_held  <= 1'b0;
          end
        end
        ST_REL: begin
          // no re-request until the mutex has withdrawn its grant
          if (!w_gnt_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req_o <= 1'b0;
          r_held  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_o = r_req_o;
  assign held  = r_held;
  assign busy  = r_busy;
  assign ack   = r_ack;

endmodule
